// File: rtl/ps2_cursor_mmio_if.sv
// rtl/ps2_cursor_mmio_if.sv - mouse packet inputs and CPU register port for the cursor block
interface ps2_cursor_mmio_if;
    logic        iTrig;
    logic [15:0] iXpos;
    logic [15:0] iYpos;
    logic [7:0]  iKey;
    logic [1:0]  iAddr;
    logic        iRdEn;
    logic        iWrEn;
    logic [31:0] iWrData;
    logic [31:0] oRdData;
    logic        oIrq;

    modport master (
        output iTrig, iXpos, iYpos, iKey, iAddr, iRdEn, iWrEn, iWrData,
        input  oRdData, oIrq
    );

    modport slave (
        input  iTrig, iXpos, iYpos, iKey, iAddr, iRdEn, iWrEn, iWrData,
        output oRdData, oIrq
    );
endinterface

// File: rtl/ps2_cursor_mmio.sv
// rtl/ps2_cursor_mmio.sv - screen-bounded cursor, button events and IRQ behind a four-word register file
module ps2_cursor_mmio #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic CLOCK,
    input  logic RESET,
    ps2_cursor_mmio_if.slave bus
);
    localparam logic [15:0] X_MAX  = 16'(SCREEN_W - 1);
    localparam logic [15:0] Y_MAX  = 16'(SCREEN_H - 1);
    localparam logic [15:0] X_HOME = 16'(SCREEN_W / 2);
    localparam logic [15:0] Y_HOME = 16'(SCREEN_H / 2);

    logic        primed, trig_d1, mv_v;
    logic [15:0] last_x, last_y, dx, dy;
    logic [15:0] cur_x, cur_y;
    logic        level, press_f, release_f, move_f;
    logic        irq_en, freeze;
    logic [31:0] rd_q, rd_mux;
    logic        irq_q;

    logic        wr_x, wr_y, wr_st, wr_ctrl, apply;
    logic        set_press, set_release, set_move;
    logic [2:0]  clr;
    logic        unused_bits;

    assign unused_bits = ^{bus.iKey[7:1], bus.iWrData[31:16]};

    // Signed step in 18 bits so both underflow and overflow are visible before clamping.
    function automatic logic [15:0] step(input logic [15:0] cur, input logic [15:0] d,
                                         input logic [15:0] maxv);
        logic signed [17:0] s;
        s = $signed({2'b00, cur}) + $signed({{2{d[15]}}, d});
        if (s < 18'sd0)
            return 16'd0;
        else if (s > $signed({2'b00, maxv}))
            return maxv;
        else
            return s[15:0];
    endfunction

    function automatic logic [15:0] wr_clamp(input logic [15:0] v, input logic [15:0] maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always_comb begin
        wr_x        = bus.iWrEn && (bus.iAddr == 2'd0);
        wr_y        = bus.iWrEn && (bus.iAddr == 2'd1);
        wr_st       = bus.iWrEn && (bus.iAddr == 2'd2);
        wr_ctrl     = bus.iWrEn && (bus.iAddr == 2'd3);
        apply       = mv_v && !freeze;
        set_press   = trig_d1 && !level && bus.iKey[0];
        set_release = trig_d1 && level && !bus.iKey[0];
        set_move    = apply && ((dx != 16'd0) || (dy != 16'd0));
        clr         = wr_st ? bus.iWrData[3:1] : 3'b000;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.iAddr)
            2'd0:    rd_mux[15:0] = cur_x;
            2'd1:    rd_mux[15:0] = cur_y;
            2'd2:    rd_mux[3:0]  = {move_f, release_f, press_f, level};
            default: rd_mux[1:0]  = {freeze, irq_en};
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            primed    <= 1'b0;
            trig_d1   <= 1'b0;
            mv_v      <= 1'b0;
            last_x    <= '0;
            last_y    <= '0;
            dx        <= '0;
            dy        <= '0;
            cur_x     <= X_HOME;
            cur_y     <= Y_HOME;
            level     <= 1'b0;
            press_f   <= 1'b0;
            release_f <= 1'b0;
            move_f    <= 1'b0;
            irq_en    <= 1'b0;
            freeze    <= 1'b0;
            rd_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            primed  <= 1'b1;
            trig_d1 <= bus.iTrig;
            last_x  <= bus.iXpos;
            last_y  <= bus.iYpos;
            mv_v    <= trig_d1 && primed;
            if (trig_d1 && primed) begin
                dx <= bus.iXpos - last_x;
                dy <= bus.iYpos - last_y;
            end
            if (trig_d1)
                level <= bus.iKey[0];

            // A CPU write to an axis overrides that axis' delta only.
            if (wr_x)
                cur_x <= wr_clamp(bus.iWrData[15:0], X_MAX);
            else if (apply)
                cur_x <= step(cur_x, dx, X_MAX);
            if (wr_y)
                cur_y <= wr_clamp(bus.iWrData[15:0], Y_MAX);
            else if (apply)
                cur_y <= step(cur_y, dy, Y_MAX);

            press_f   <= (press_f   && !clr[0]) || set_press;
            release_f <= (release_f && !clr[1]) || set_release;
            move_f    <= (move_f    && !clr[2]) || set_move;

            if (wr_ctrl) begin
                irq_en <= bus.iWrData[0];
                freeze <= bus.iWrData[1];
            end
            if (bus.iRdEn)
                rd_q <= rd_mux;
            irq_q <= irq_en && (press_f || release_f || move_f);
        end
    end

    assign bus.oRdData = rd_q;
    assign bus.oIrq    = irq_q;
endmodule

// File: tb/tb_ps2_cursor_mmio.sv
// tb/tb_ps2_cursor_mmio.sv - scoreboard bench: reads queue expectations, a monitor checks returned data
module tb_ps2_cursor_mmio;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    ps2_cursor_mmio_if bus ();

    ps2_cursor_mmio #(.SCREEN_W(640), .SCREEN_H(480)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;
    string       q_name[$];
    logic [31:0] q_data[$];
    logic        q_irq[$];
    logic        rd_valid = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(posedge CLOCK) rd_valid <= bus.iRdEn;

    always @(negedge CLOCK) begin
        if (rd_valid) begin
            if (q_data.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read actual=%0d expected=none", bus.oRdData);
            end else begin
                string nm;
                logic [31:0] e;
                logic ei;
                nm = q_name.pop_front();
                e  = q_data.pop_front();
                ei = q_irq.pop_front();
                check({nm, "_data"}, bus.oRdData, e);
                check({nm, "_irq"}, {31'd0, bus.oIrq}, {31'd0, ei});
            end
        end
    end

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic ei, input string nm);
        q_name.push_back(nm);
        q_data.push_back(e);
        q_irq.push_back(ei);
        bus.iAddr = a;
        bus.iRdEn = 1'b1;
        tick();
        bus.iRdEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.iAddr   = a;
        bus.iWrData = d;
        bus.iWrEn   = 1'b1;
        tick();
        bus.iWrEn   = 1'b0;
    endtask

    // wr_at: 0 none, 1 concurrent with trig_d1, 2 concurrent with the apply cycle
    task automatic pkt(input logic [15:0] x, input logic [15:0] y, input logic key,
                       input int wr_at, input logic [1:0] wa, input logic [31:0] wd);
        bus.iTrig = 1'b1;
        tick();
        bus.iTrig = 1'b0;
        bus.iXpos = x;
        bus.iYpos = y;
        bus.iKey  = {7'd0, key};
        if (wr_at == 1) begin bus.iAddr = wa; bus.iWrData = wd; bus.iWrEn = 1'b1; end
        tick();
        bus.iWrEn = 1'b0;
        if (wr_at == 2) begin bus.iAddr = wa; bus.iWrData = wd; bus.iWrEn = 1'b1; end
        tick();
        bus.iWrEn = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.iTrig = 0; bus.iXpos = 0; bus.iYpos = 0; bus.iKey = 0;
        bus.iAddr = 0; bus.iRdEn = 0; bus.iWrEn = 0; bus.iWrData = 0;
        repeat (3) tick();
        @(negedge CLOCK);
        check("rst_rddata", bus.oRdData, 32'd0);
        check("rst_irq", {31'd0, bus.oIrq}, 32'd0);
        RESET = 1'b0;
        tick();

        rd(0, 320, 0, "rst_x");
        rd(1, 240, 0, "rst_y");
        rd(2, 0, 0, "rst_status");
        rd(3, 0, 0, "rst_ctrl");

        wr(3, 1);
        pkt(16'd10, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 330, 1, "step_x");
        rd(1, 235, 1, "step_y");
        rd(2, 8, 1, "step_status");
        wr(2, 8);
        tick(); tick();
        rd(2, 0, 0, "w1c_move");

        pkt(16'hFC22, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 0, 1, "clamp_lo");
        pkt(16'd10, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 639, 1, "clamp_hi");
        wr(2, 32'hE);
        wr(3, 0);

        wr(3, 2);
        pkt(16'h7FFF, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 639, 0, "frz_big_x");
        rd(2, 0, 0, "frz_big_status");
        rd(3, 2, 0, "frz_ctrl");
        wr(3, 0);
        wr(0, 100);
        pkt(16'h8001, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 102, 0, "wrap_x");
        rd(2, 8, 0, "wrap_status");
        wr(2, 32'hE);
        wr(3, 2);
        pkt(16'h8015, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 102, 0, "frz_x");
        rd(2, 0, 0, "frz_status");
        wr(3, 0);
        pkt(16'h8016, 16'hFFFB, 0, 0, 0, 0);
        rd(0, 103, 0, "unfrz_x");
        wr(2, 32'hE);

        pkt(16'h8016, 16'hFFFB, 1, 0, 0, 0);
        rd(2, 3, 0, "press");
        pkt(16'h8016, 16'hFFFB, 0, 0, 0, 0);
        rd(2, 6, 0, "release");
        wr(2, 32'hE);
        pkt(16'h8016, 16'hFFFB, 1, 1, 2, 32'h2);
        rd(2, 3, 0, "w1c_vs_press");
        wr(2, 32'hE);

        wr(0, 700);
        rd(0, 639, 0, "wr_clamp_x");
        pkt(16'h801B, 16'hFFFE, 1, 2, 0, 50);
        rd(0, 50, 0, "wr_vs_apply_x");
        rd(1, 238, 0, "wr_vs_apply_y");
        rd(2, 9, 0, "wr_vs_apply_status");
        wr(1, 32'h1E0);
        rd(1, 479, 0, "wr_clamp_y");
        wr(1, 0);
        rd(1, 0, 0, "wr_y_zero");

        bus.iTrig = 1'b1;
        tick();
        bus.iXpos = 16'h801E;
        tick();
        bus.iTrig = 1'b0;
        bus.iXpos = 16'h8020;
        repeat (4) tick();
        rd(0, 55, 0, "b2b_x");

        bus.iTrig = 1'b1;
        tick();
        bus.iTrig = 1'b0;
        bus.iXpos = 16'h8040;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (4) tick();
        rd(0, 320, 0, "midrst_x");
        rd(2, 0, 0, "midrst_status");

        for (int i = 0; i < 20; i++) begin
            if (q_data.size() == 0) break;
            tick();
        end
        check("sb_drain", q_data.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_cursor_mmio.md
# ps2_cursor_mmio

Downstream consumer of the PS/2 mouse base module. It converts the accumulated 16-bit mouse position totals into a screen-bounded cursor position, tracks left-button state with sticky press/release/move events and an interrupt, and exposes all of it to the RISC-V core as a four-word memory-mapped register file.

## Interface
Parameters:
- SCREEN_W, 640, cursor X range is 0..SCREEN_W-1
- SCREEN_H, 480, cursor Y range is 0..SCREEN_H-1

Ports (one clock; reset is synchronous and active-high):
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- iTrig  in  1  one-cycle pulse from the mouse base module, one per received packet
- iXpos  in  16  accumulated X total, two's complement, wraps mod 2^16
- iYpos  in  16  accumulated Y total, two's complement, wraps mod 2^16, increasing = cursor down
- iKey  in  8  button vector; bit0 = left button, others ignored
- iAddr  in  2  word index into the register map
- iRdEn  in  1  read strobe
- iWrEn  in  1  write strobe
- iWrData  in  32  write data
- oRdData  out  32  registered read data
- oIrq  out  1  level interrupt

## Operation
- Register map: 0 CUR_X (R/W, bits[15:0]); 1 CUR_Y (R/W, bits[15:0]); 2 STATUS (bit0 button level RO; bit1 PRESS, bit2 RELEASE, bit3 MOVE, all write-1-to-clear); 3 CTRL (R/W; bit0 IRQ_EN, bit1 FREEZE). Unused bits read 0.
- Delta extraction: last_x/last_y load iXpos/iYpos every cycle. PRIMED clears on reset and sets on the first cycle after reset. In cycle trig_d1 (iTrig delayed 1) with PRIMED=1: dx = iXpos - last_x, dy = iYpos - last_y (16-bit wrap, signed). The results are registered with mv_v.
- Apply stage (mv_v=1, FREEZE=0): sum = cur + sign-extended delta, computed in 18-bit signed arithmetic. sum<0 gives 0. sum>limit-1 gives limit-1. MOVE sets if dx!=0 or dy!=0, even when the result is clamped.
- FREEZE=1: deltas are discarded and MOVE does not set. last_x/last_y keep tracking, so the cursor does not jump when FREEZE clears.
- Button: in cycle trig_d1, the level register takes iKey[0]. A 0->1 change sets PRESS; a 1->0 change sets RELEASE.
- CPU write to CUR_X/CUR_Y: wr_data[15:0] as unsigned, clamped to limit-1 if greater than or equal to the limit.
- oIrq = IRQ_EN & (PRESS | RELEASE | MOVE).

Reset values:
- cur_x = SCREEN_W/2, cur_y = SCREEN_H/2
- STATUS = 0, CTRL = 0, oRdData = 0, oIrq = 0
- PRIMED = 0, pipeline valids = 0

Reset mid-packet: pipeline valids clear, and any in-flight delta is discarded.

Simultaneous events:
- CPU write to CUR_X or CUR_Y in the same cycle as an apply for that axis: the write wins and the delta is dropped for that axis only.
- W1C in the same cycle as a new set of the same flag: the set wins.
- Read and write in the same cycle: the read returns the pre-write value.

## Timing
- iTrig in cycle T. iXpos/iYpos are valid in T+1 (trig_d1). The delta is registered at the end of T+1. The apply happens in T+2. The new CUR_X/CUR_Y and MOVE flag are visible from T+3.
- Button level, PRESS and RELEASE are visible from T+2. oIrq follows the flags by one cycle after they set (registered).
- iRdEn in cycle N: oRdData is valid in N+1 and held until the next read.
- iWrEn takes effect at the end of the same cycle.
- Back-to-back iTrig pulses every cycle are supported. Each delta is applied exactly once; the block has no throttling.

## Test plan
- Reset, then read CUR_X/CUR_Y/STATUS -> 320, 240, 0; oIrq=0.
- Step iXpos 0->+10 and iYpos 0->-5 with iTrig -> CUR_X=330, CUR_Y=235, MOVE=1 at T+3. With IRQ_EN=1, oIrq=1. W1C of bit3 drops oIrq.
- iXpos delta -1000 from X=330, then +1000 -> CUR_X=0, then CUR_X=639. Also apply a wrap case with iXpos going 0x7FFF->0x8001 (delta +2) -> X increases by 2.
- iKey[0] 0->1->0 across three packets -> PRESS set on the second packet and RELEASE on the third. A W1C of PRESS in the same cycle as a new press leaves PRESS=1.
- CPU writes CUR_X=700 -> reads 639. A write in the same cycle as an apply keeps the written value, and the Y delta is still applied.
- FREEZE=1 with a +20 X packet -> CUR_X unchanged and MOVE=0. Clear FREEZE, then send a +1 packet -> X increases by exactly 1.
